// File: rtl/execute_mc.sv
// Execute stage: ALU with Z/C/N/V flags plus a multi-cycle req/ack data-memory port
// with stall back-pressure, a wait timeout and a sticky error flag.
module execute_mc #(
    parameter int DATA_W      = 8,
    parameter int ADDR_W      = 12,
    parameter int MEM_TIMEOUT = 15,
    parameter int TO_CNT_W    = 8
) (
    input  logic              clk,
    input  logic              reset_,
    input  logic              exec_en,
    input  logic [3:0]        exec_ctrl,
    input  logic [2:0]        dst_reg,
    input  logic [ADDR_W-1:0] dst_addr,
    input  logic [DATA_W-1:0] reg_src0_data,
    input  logic [DATA_W-1:0] reg_src1_data,
    input  logic [DATA_W-1:0] imm_data,
    input  logic              imm_data_vld,
    output logic [DATA_W-1:0] reg_wr_data,
    output logic [2:0]        reg_wr_sel,
    output logic              reg_wr_en,
    output logic [3:0]        flags,
    output logic              stall,
    output logic [ADDR_W-1:0] d_mem_addr,
    output logic [DATA_W-1:0] d_mem_data_out,
    output logic              d_mem_req,
    output logic              d_mem_we,
    input  logic [DATA_W-1:0] d_mem_data_in,
    input  logic              d_mem_ack,
    output logic              mem_err
);

    localparam logic [3:0] OP_NOP = 4'd0,  OP_ADD = 4'd1,  OP_SUB = 4'd2,  OP_OR  = 4'd3;
    localparam logic [3:0] OP_AND = 4'd4,  OP_XOR = 4'd5,  OP_MRD = 4'd6,  OP_MWR = 4'd7;
    localparam logic [3:0] OP_ADC = 4'd11, OP_SBB = 4'd12, OP_SHL = 4'd13, OP_SHR = 4'd14;
    localparam logic [TO_CNT_W-1:0] TO_LAST = TO_CNT_W'(MEM_TIMEOUT - 1);
    localparam logic [TO_CNT_W-1:0] TO_ONE  = TO_CNT_W'(1);

    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_EXEC = 2'd1, ST_MEM_WAIT = 2'd2} state_t;

    state_t              state_r, state_nxt_s;
    logic [3:0]          op_r;
    logic [2:0]          dst_r;
    logic [ADDR_W-1:0]   addr_r, mem_addr_r;
    logic [DATA_W-1:0]   mem_data_r, op_b_s, alu_res_s;
    logic [DATA_W:0]     sum_s;
    logic [TO_CNT_W-1:0] cnt_r;
    logic [3:0]          flags_r;
    logic                mem_we_r, mem_err_r;
    logic                issue_s, exec_mem_s, ack_s, timeout_s, stall_s;
    logic                alu_wr_s, alu_c_s, alu_v_s;

    function automatic logic add_ovf(input logic a_msb, input logic b_msb, input logic r_msb);
        return (a_msb == b_msb) && (r_msb != a_msb);
    endfunction

    function automatic logic sub_ovf(input logic a_msb, input logic b_msb, input logic r_msb);
        return (a_msb != b_msb) && (r_msb != a_msb);
    endfunction

    assign op_b_s     = imm_data_vld ? imm_data : reg_src1_data;
    assign exec_mem_s = (state_r == ST_EXEC) && ((op_r == OP_MRD) || (op_r == OP_MWR));
    assign stall_s    = exec_mem_s || (state_r == ST_MEM_WAIT);
    assign issue_s    = exec_en && !stall_s;
    assign ack_s      = (state_r == ST_MEM_WAIT) && d_mem_ack;
    // ack in the final counted cycle still counts as a normal completion
    assign timeout_s  = (state_r == ST_MEM_WAIT) && !d_mem_ack && (cnt_r == TO_LAST);

    // ALU: result, carry/borrow and signed overflow for the staged op
    always_comb begin
        sum_s     = '0;
        alu_res_s = '0;
        alu_c_s   = 1'b0;
        alu_v_s   = 1'b0;
        alu_wr_s  = 1'b1;
        case (op_r)
            OP_ADD, OP_ADC: begin
                sum_s     = {1'b0, reg_src0_data} + {1'b0, op_b_s}
                          + {{DATA_W{1'b0}}, (op_r == OP_ADC) & flags_r[1]};
                alu_res_s = sum_s[DATA_W-1:0];
                alu_c_s   = sum_s[DATA_W];
                alu_v_s   = add_ovf(reg_src0_data[DATA_W-1], op_b_s[DATA_W-1], alu_res_s[DATA_W-1]);
            end
            OP_SUB, OP_SBB: begin
                sum_s     = {1'b0, reg_src0_data} - {1'b0, op_b_s}
                          - {{DATA_W{1'b0}}, (op_r == OP_SBB) & flags_r[1]};
                alu_res_s = sum_s[DATA_W-1:0];
                alu_c_s   = sum_s[DATA_W];
                alu_v_s   = sub_ovf(reg_src0_data[DATA_W-1], op_b_s[DATA_W-1], alu_res_s[DATA_W-1]);
            end
            OP_OR:  alu_res_s = reg_src0_data | op_b_s;
            OP_AND: alu_res_s = reg_src0_data & op_b_s;
            OP_XOR: alu_res_s = reg_src0_data ^ op_b_s;
            OP_SHL: begin
                alu_res_s = {reg_src0_data[DATA_W-2:0], 1'b0};
                alu_c_s   = reg_src0_data[DATA_W-1];
            end
            OP_SHR: begin
                alu_res_s = {1'b0, reg_src0_data[DATA_W-1:1]};
                alu_c_s   = reg_src0_data[0];
            end
            default: alu_wr_s = 1'b0;
        endcase
    end

    // next-state logic
    always_comb begin
        state_nxt_s = ST_IDLE;
        case (state_r)
            ST_IDLE: state_nxt_s = issue_s ? ST_EXEC : ST_IDLE;
            ST_EXEC: begin
                if (exec_mem_s) begin
                    state_nxt_s = ST_MEM_WAIT;
                end else begin
                    state_nxt_s = issue_s ? ST_EXEC : ST_IDLE;
                end
            end
            ST_MEM_WAIT: begin
                if (ack_s || timeout_s) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_MEM_WAIT;
                end
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // writeback: ALU result in its exec cycle, load data in the ack cycle
    always_comb begin
        reg_wr_en   = 1'b0;
        reg_wr_data = '0;
        reg_wr_sel  = 3'd0;
        if ((state_r == ST_EXEC) && alu_wr_s) begin
            reg_wr_en   = 1'b1;
            reg_wr_data = alu_res_s;
            reg_wr_sel  = dst_r;
        end else if (ack_s && !mem_we_r) begin
            reg_wr_en   = 1'b1;
            reg_wr_data = d_mem_data_in;
            reg_wr_sel  = dst_r;
        end else begin
            reg_wr_en   = 1'b0;
        end
    end

    // the exec cycle of a memory op drives the port directly; the latches hold it afterwards
    assign d_mem_req      = stall_s;
    assign stall          = stall_s;
    assign d_mem_addr     = exec_mem_s ? addr_r : mem_addr_r;
    assign d_mem_data_out = exec_mem_s ? reg_src0_data : mem_data_r;
    assign d_mem_we       = exec_mem_s ? (op_r == OP_MWR) : mem_we_r;
    assign flags          = flags_r;
    assign mem_err        = mem_err_r;

    // state, issue stage, memory latches, timeout counter and flags
    always_ff @(posedge clk) begin
        if (reset_) begin
            state_r    <= ST_IDLE;
            op_r       <= OP_NOP;
            dst_r      <= 3'd0;
            addr_r     <= '0;
            mem_addr_r <= '0;
            mem_data_r <= '0;
            mem_we_r   <= 1'b0;
            cnt_r      <= '0;
            flags_r    <= 4'd0;
            mem_err_r  <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            op_r    <= issue_s ? exec_ctrl : OP_NOP;
            if (issue_s) begin
                dst_r  <= dst_reg;
                addr_r <= dst_addr;
            end
            if (exec_mem_s) begin
                mem_addr_r <= addr_r;
                mem_data_r <= reg_src0_data;
                mem_we_r   <= (op_r == OP_MWR);
                cnt_r      <= '0;
            end else if (state_r == ST_MEM_WAIT) begin
                cnt_r <= cnt_r + TO_ONE;
            end
            if ((state_r == ST_EXEC) && alu_wr_s) begin
                flags_r <= {alu_v_s, alu_res_s[DATA_W-1], alu_c_s, (alu_res_s == '0)};
            end
            if (timeout_s) begin
                mem_err_r <= 1'b1;
            end
        end
    end

endmodule

// File: doc/execute_mc.md
Name: execute_mc

Overview:
- Parametrised successor of the CPU execute stage. Sits between decode/register-file and data memory.
- Adds configurable data/address width, a flags register (Z/C/N/V), carry-chained and shift ALU ops, and a multi-cycle req/ack data-memory handshake with back-pressure (stall) to decode.
- Adds a memory timeout counter with a sticky error flag.

Parameters:
- DATA_W, 8, datapath/register width (>=4)
- ADDR_W, 12, data-memory address width
- MEM_TIMEOUT, 15, max cycles waiting for d_mem_ack before abort (1..255)
- TO_CNT_W, 8, timeout counter width (2^TO_CNT_W > MEM_TIMEOUT)

Ports:
- clk  in  1  sole clock, rising edge
- reset_  in  1  synchronous, active-high reset (sampled on clk; high = reset)
- exec_en  in  1  issue strobe from decode
- exec_ctrl  in  4  op code (encoding below)
- dst_reg  in  3  destination register select
- dst_addr  in  ADDR_W  memory address for MEM ops
- reg_src0_data  in  DATA_W  operand A (valid 1 cycle after issue)
- reg_src1_data  in  DATA_W  operand B register (valid 1 cycle after issue)
- imm_data  in  DATA_W  immediate (valid 1 cycle after issue)
- imm_data_vld  in  1  select imm_data as operand B (sampled with operands)
- reg_wr_data  out  DATA_W  writeback data
- reg_wr_sel  out  3  writeback register
- reg_wr_en  out  1  writeback strobe, 1 cycle per op
- flags  out  4  {V,N,C,Z}
- stall  out  1  decode must hold issue while high
- d_mem_addr  out  ADDR_W  memory address
- d_mem_data_out  out  DATA_W  store data
- d_mem_req  out  1  memory request
- d_mem_we  out  1  1 = write, 0 = read (qualified by req)
- d_mem_data_in  in  DATA_W  load data (valid with ack)
- d_mem_ack  in  1  request completion
- mem_err  out  1  sticky timeout error

Behaviour:
- Op encoding: 0 NOP, 1 ADD, 2 SUB, 3 OR, 4 AND, 5 XOR, 6 MEM_RD, 7 MEM_WR, 8 JMP, 9 CALL, 10 RET, 11 ADC, 12 SBB, 13 SHL, 14 SHR, 15 IDLE. Ops 8/9/10/15 are no-ops here: no write, no flag change.
- Issue: when exec_en && !stall, register exec_ctrl, dst_reg and dst_addr into the stage (1-cycle delay, matching operand read latency). When exec_en is low, the stage loads NOP. Issue while stall is high is ignored.
- Operand B = imm_data_vld ? imm_data : reg_src1_data.
- State machine:
  - IDLE: no op in flight.
  - EXEC: stage op active for 1 cycle.
  - MEM_WAIT: handshake outstanding.
- EXEC, ALU op: reg_wr_en=1 combinationally that cycle; reg_wr_sel = staged dst_reg; result mod 2^DATA_W.
  - ADC: A+B+C. SBB: A-B-C.
  - SHL: A<<1, C=A[msb]. SHR: logical A>>1, C=A[0].
  - ADD/ADC: C = carry out. SUB/SBB: C = borrow.
  - Z = (result==0). N = result[msb].
  - V = signed overflow for ADD/ADC/SUB/SBB; V=0 for logic and shift ops.
  - OR/AND/XOR: C=0.
  - Flags register at the end of the EXEC cycle.
- EXEC, MEM op: in the same cycle, latch A into d_mem_data_out and the staged dst_addr into d_mem_addr. Assert d_mem_req, set d_mem_we per op, go to MEM_WAIT. stall=1 from this cycle.
- MEM_WAIT:
  - req, addr, we and data_out held stable; timeout counter increments each cycle.
  - On d_mem_ack: deassert req the next cycle, clear stall the next cycle, return to IDLE. For MEM_RD, reg_wr_en=1 with reg_wr_data = d_mem_data_in in the ack cycle. MEM ops never change flags.
  - If the counter reaches MEM_TIMEOUT with no ack: drop req, set mem_err, no writeback, return to IDLE.
  - An ack arriving in the same cycle the counter reaches MEM_TIMEOUT wins: normal completion, no error.
  - An ack while not in MEM_WAIT is ignored.
- Back-to-back ALU ops: no stall, one writeback per cycle. An issue is accepted in the cycle after stall drops.
- mem_err is cleared only by reset.
- Reset (takes effect at any time, including mid-MEM_WAIT):
  - State IDLE, stage = NOP, counter 0.
  - reg_wr_en=0, reg_wr_data=0, reg_wr_sel=0.
  - flags=0, stall=0, d_mem_req=0, d_mem_we=0, d_mem_addr=0, d_mem_data_out=0, mem_err=0.
  - The request is dropped without writeback.

Test Plan:
- Arithmetic flags:
  - ADD A=0x7F, B=imm 0x01 (imm_data_vld=1), dst=3 -> next cycle reg_wr_en=1, sel=3, data=0x80, flags V=1 N=1 C=0 Z=0.
  - Then ADC A=0xFF, B=0x01 -> data=0x00, C=1, Z=1.
  - Then ADC 0x00+0x00 -> 0x01.
- Load with latency: MEM_RD addr 0x123, ack after 3 wait cycles with data 0x5A -> req high and addr stable for 4 cycles, stall high over the same window, single reg_wr_en with 0x5A in the ack cycle, flags unchanged.
- Store: MEM_WR A=0xC3 at 0x0FF, exec_en held high during stall -> d_mem_we=1, data_out=0xC3 stable, no writeback; the held issue is accepted only after stall drops.
- Timeout: MEM_RD with ack never asserted, MEM_TIMEOUT=15 -> req drops after 15 wait cycles, mem_err=1 and stays 1, no writeback. A later ALU op works normally.
- Ack/timeout tie and reset: ack exactly at count 15 -> completion, mem_err=0. reset_ asserted mid-MEM_WAIT -> next cycle all outputs 0, state IDLE, no writeback.
- Shift/logic, DATA_W=16 build: SHR A=0x0001 -> 0x0000, C=1, Z=1. XOR 0xFFFF^0xFFFF -> Z=1, C=0, V=0. Back-to-back ops -> one write per cycle, stall never asserted.
